// File: rtl/axi_lite_master_cmd.sv
// Single-outstanding register-command to AXI4-Lite master bridge.
// Optional abort-on-timeout is compiled in with AXI_MASTER_CMD_TIMEOUT_EN.
module axi_lite_master_cmd #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_axi_clk,
  input  logic                  i_axi_rst,
  // Command / response
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_wr,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [31:0]           i_cmd_wdata,
  input  logic [3:0]            i_cmd_wstrb,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_rdata,
  output logic [1:0]            o_rsp_resp,
  output logic                  o_rsp_timeout,
  // AXI4-Lite write channels
  output logic                  o_awvalid,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  input  logic                  i_awready,
  output logic                  o_wvalid,
  output logic [31:0]           o_wdata,
  output logic [3:0]            o_wstrb,
  input  logic                  i_wready,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [1:0]            i_bresp,
  // AXI4-Lite read channels
  output logic                  o_arvalid,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  input  logic                  i_arready,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [1:0]            i_rresp,
  input  logic [31:0]           i_rdata
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrite = 3'd1;
  localparam logic [2:0] StWresp = 3'd2;
  localparam logic [2:0] StRead  = 3'd3;
  localparam logic [2:0] StRdata = 3'd4;
  localparam logic [2:0] StResp  = 3'd5;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;

`ifdef AXI_MASTER_CMD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            active, handshake, expired;

  assign active    = (state_q == StWrite) || (state_q == StWresp) ||
                     (state_q == StRead)  || (state_q == StRdata);
  // Any handshake this cycle defers the abort by at least one cycle.
  assign handshake = (awvalid_q & i_awready) | (wvalid_q & i_wready) |
                     (bready_q & i_bvalid) | (arvalid_q & i_arready) |
                     (rready_q & i_rvalid);
  assign expired   = active && !handshake && (cnt_q >= CntW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;

    case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_wdata;
          wstrb_d = i_cmd_wstrb;
          if (i_cmd_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrite;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRead;
          end
        end
      end
      StWrite: begin
        if (awvalid_q && i_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = StWresp;
        end
      end
      StWresp: begin
        if (i_bvalid) begin
          resp_d   = i_bresp;
          rdata_d  = '0;
          bready_d = 1'b0;
          state_d  = StResp;
        end
      end
      StRead: begin
        if (i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdata;
        end
      end
      StRdata: begin
        if (i_rvalid) begin
          rdata_d  = i_rdata;
          resp_d   = i_rresp;
          rready_d = 1'b0;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (i_rsp_ready) state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase

`ifdef AXI_MASTER_CMD_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == StIdle && i_cmd_valid) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (active) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (expired) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      rdata_d   = '0;
      resp_d    = 2'b10;
      timeout_d = 1'b1;
      state_d   = StResp;
    end
`endif
  end

  always_ff @(posedge i_axi_clk) begin
    if (!i_axi_rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
`ifdef AXI_MASTER_CMD_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
`ifdef AXI_MASTER_CMD_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_cmd_ready = (state_q == StIdle);
  assign o_rsp_valid = (state_q == StResp);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_resp  = resp_q;
  assign o_awvalid   = awvalid_q;
  assign o_awaddr    = addr_q;
  assign o_wvalid    = wvalid_q;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = wstrb_q;
  assign o_bready    = bready_q;
  assign o_arvalid   = arvalid_q;
  assign o_araddr    = addr_q;
  assign o_rready    = rready_q;

`ifdef AXI_MASTER_CMD_TIMEOUT_EN
  assign o_rsp_timeout = timeout_q;
`else
  assign o_rsp_timeout = 1'b0;
`endif

endmodule
